tree_plru_array: RTL and testbench
==================================

TREE_PLRU_ARRAY -- requirements
Module: tree_plru_array

Interface
REQ-001 SHALL have parameter WAYS, default 4: associativity; power of 2, range 2..16.
REQ-002 SHALL have parameter SETS, default 128: number of sets; power of 2, at least 2.
REQ-003 SHALL derive local parameters IDXW = log2(SETS) and WAYW = log2(WAYS).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port resetn  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port flush  input  1  pulse; clears every set's state to 0.
REQ-007 SHALL have port busy  output  1  high while the clear sequence runs.
REQ-008 SHALL have port rd_en  input  1  victim lookup request.
REQ-009 SHALL have port rd_index  input  IDXW  set to look up.
REQ-010 SHALL have port rd_valid  input  WAYS  line-valid bits of the looked-up set, sampled with rd_en.
REQ-011 SHALL have port lock_mask  input  WAYS  ways excluded from replacement, sampled with rd_en.
REQ-012 SHALL have port victim_vld  output  1  victim outputs valid this cycle.
REQ-013 SHALL have port victim  output  WAYW  binary victim way.
REQ-014 SHALL have port victim_oh  output  WAYS  one-hot victim way; all zero when victim_ok=0.
REQ-015 SHALL have port victim_ok  output  1  0 when every way is locked.
REQ-016 SHALL have port upd_en  input  1  access notification (hit or refill).
REQ-017 SHALL have port upd_index  input  IDXW  set that was accessed.
REQ-018 SHALL have port upd_way_oh  input  WAYS  accessed way; the highest set bit wins; all zero means no update.

Function
REQ-019 SHALL hold WAYS-1 tree bits per set, with nodes heap-numbered (root 0; children of node n are 2n+1 and 2n+2) and leaves mapping to ways 0..WAYS-1 left to right.
REQ-020 SHALL define node bit 0 as "victim lies in the left subtree" and 1 as "victim lies in the right subtree".
REQ-021 SHALL, on an accepted update, set every node on the accessed way's path to point away from that way and leave all other nodes unchanged.
REQ-022 SHALL register the update at the clock edge; upd_en when not busy is the only accepted update.
REQ-023 SHALL produce victim_vld, victim, victim_oh and victim_ok exactly 1 cycle after an accepted rd_en (rd_en with busy=0), and hold victim_vld at 0 otherwise.
REQ-024 SHALL choose the victim with priority (a) the lowest-index way with rd_valid=0 and lock_mask=0, then (b) the tree walk.
REQ-025 SHALL, during the tree walk, take the direction the node bit indicates unless that subtree is fully locked, in which case it takes the other subtree.
REQ-026 SHALL drive victim_ok=0, victim=0 and victim_oh=0 when lock_mask is all ones.
REQ-027 SHALL, when upd_en and rd_en target the same index in the same cycle, compute the lookup from the post-update state (write-first forwarding).
REQ-028 SHALL leave sets other than upd_index unaffected by an update.
REQ-029 SHALL implement the clear sequence as an FSM with states IDLE and CLEAR: in CLEAR, one set per cycle is zeroed from index 0 to SETS-1, after which the FSM returns to IDLE.
REQ-030 SHALL hold busy=1 for exactly SETS cycles per clear sequence.
REQ-031 SHALL ignore rd_en and upd_en while busy=1.
REQ-032 SHALL restart a flush asserted during CLEAR from index 0.
REQ-033 SHALL make a flush in IDLE give busy=1 on the following cycle.

Reset
REQ-034 SHALL, while resetn=0, enter CLEAR with the counter at 0 and drive victim_vld=0, victim=0, victim_oh=0 and victim_ok=0.
REQ-035 SHALL start the clear sequence from the first cycle after resetn returns to 1, giving busy=1 for SETS cycles.
REQ-036 SHALL treat a reset asserted mid-CLEAR or mid-lookup as aborting it and restarting per REQ-034.

Verification
REQ-037 SHALL cover: reset, wait for busy=0, then lookup set 5 with rd_valid=4'hF and lock=0 -> next cycle victim=0, victim_oh=4'b0001, victim_ok=1.
REQ-038 SHALL cover (WAYS=4): upd set 5 way 0, then lookup set 5 -> victim=2; then upd way 2, then lookup -> victim=1.
REQ-039 SHALL cover: lookup set 3 with rd_valid=4'b1011 -> victim=2 regardless of tree state; with lock_mask=4'b0100 as well -> victim follows the tree walk among ways 0, 1 and 3.
REQ-040 SHALL cover: state for set 7 reset; lock_mask=4'b0011, rd_valid=4'hF -> victim=2; lock_mask=4'hF -> victim_ok=0, victim_oh=0.
REQ-041 SHALL cover: same-cycle upd (set 9, way 0) and rd (set 9) -> victim=2, the forwarded result; the same stimulus on set 10 -> victim=0.
REQ-042 SHALL cover: a flush, then a second flush 3 cycles into CLEAR -> busy stays 1 for SETS+3 cycles total, rd_en is ignored throughout, and all sets read victim=0 afterwards.

Source files
------------

// File: rtl/tree_plru_array.sv
// ============================================================================
// Module      : tree_plru_array
// Description : Tree pseudo-LRU replacement state for a set-associative cache.
//               Holds WAYS-1 heap-ordered tree bits per set and answers victim
//               lookups one cycle later. Invalid unlocked ways are preferred;
//               otherwise the tree is walked, steering around fully locked
//               subtrees. A flush, or the release of reset, clears every set
//               one index per cycle while busy is high.
// Ports       : clk, resetn (sync, active-low), flush -> busy
//               rd_en/rd_index/rd_valid/lock_mask -> victim_vld/victim/
//               victim_oh/victim_ok (registered)
//               upd_en/upd_index/upd_way_oh : access notification
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tree_plru_array #(
    parameter int WAYS = 4,
    parameter int SETS = 128,
    localparam int IDXW = $clog2(SETS),
    localparam int WAYW = $clog2(WAYS)
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            flush,
    output logic            busy,
    input  logic            rd_en,
    input  logic [IDXW-1:0] rd_index,
    input  logic [WAYS-1:0] rd_valid,
    input  logic [WAYS-1:0] lock_mask,
    output logic            victim_vld,
    output logic [WAYW-1:0] victim,
    output logic [WAYS-1:0] victim_oh,
    output logic            victim_ok,
    input  logic            upd_en,
    input  logic [IDXW-1:0] upd_index,
    input  logic [WAYS-1:0] upd_way_oh
);

    localparam int NODES = WAYS - 1;      // tree bits per set
    localparam int HEAP  = 2 * WAYS - 1;  // internal nodes plus leaves

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   cnt_q, cnt_d;
    logic [NODES-1:0]  tree_q [SETS];

    logic              victim_vld_q, victim_vld_d;
    logic [WAYW-1:0]   victim_q, victim_d;
    logic [WAYS-1:0]   victim_oh_q, victim_oh_d;
    logic              victim_ok_q, victim_ok_d;

    logic              upd_acc;
    logic              rd_acc;
    logic [WAYW-1:0]   upd_way;
    logic [NODES-1:0]  upd_new;
    logic [NODES-1:0]  rd_tree;
    logic              free_any;
    logic [WAYW-1:0]   free_way;

    // Highest set bit of the one-hot access vector selects the way.
    function automatic logic [WAYW-1:0] oh_to_bin_hi(input logic [WAYS-1:0] oh);
        logic [WAYW-1:0] b;
        b = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (oh[i]) b = WAYW'(i);
        end
        return b;
    endfunction

    // Point every node on the way's root-to-leaf path away from that way.
    function automatic logic [NODES-1:0] touch(input logic [NODES-1:0] t,
                                               input logic [WAYW-1:0]  w);
        logic [NODES-1:0] r;
        int               n;
        r = t;
        n = 0;
        for (int d = 0; d < WAYW; d++) begin
            for (int k = 0; k < NODES; k++) begin
                if (k == n) r[k] = ~w[WAYW-1-d];
            end
            n = 2 * n + 1 + int'(w[WAYW-1-d]);
        end
        return r;
    endfunction

    // Walk the tree; a fully locked child forces the other direction.
    // The root subtree is never fully locked when this result is used.
    function automatic logic [WAYW-1:0] walk(input logic [NODES-1:0] t,
                                             input logic [WAYS-1:0]  lk);
        logic [HEAP-1:0] full;
        logic            go;
        int              n;
        full = '0;
        for (int w = 0; w < WAYS; w++) full[NODES+w] = lk[w];
        for (int k = NODES - 1; k >= 0; k--) full[k] = full[2*k+1] & full[2*k+2];
        n = 0;
        for (int d = 0; d < WAYW; d++) begin
            go = 1'b0;
            for (int k = 0; k < NODES; k++) begin
                if (k == n) go = t[k] ? ~full[2*k+2] : full[2*k+1];
            end
            n = 2 * n + 1 + int'(go);
        end
        return WAYW'(n - NODES);
    endfunction

    // Clear sequencer
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                if (flush)                          cnt_d   = '0;
                else if (cnt_q == IDXW'(SETS - 1))  state_d = IDLE;
                else                                cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == CLEAR);

    // Update path and write-first forwarding into the lookup
    always_comb begin
        upd_acc = upd_en & ~busy & (|upd_way_oh);
        rd_acc  = rd_en & ~busy;
        upd_way = oh_to_bin_hi(upd_way_oh);
        upd_new = touch(tree_q[upd_index], upd_way);
        rd_tree = (upd_acc && (upd_index == rd_index)) ? upd_new : tree_q[rd_index];
    end

    // Lowest-index way that is both invalid and unlocked
    always_comb begin
        free_any = 1'b0;
        free_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!rd_valid[i] && !lock_mask[i]) begin
                free_any = 1'b1;
                free_way = WAYW'(i);
            end
        end
    end

    always_comb begin
        victim_vld_d = rd_acc;
        victim_ok_d  = 1'b0;
        victim_d     = '0;
        victim_oh_d  = '0;
        if (rd_acc && !(&lock_mask)) begin
            victim_ok_d = 1'b1;
            victim_d    = free_any ? free_way : walk(rd_tree, lock_mask);
            victim_oh_d = WAYS'(1) << victim_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= CLEAR;
            cnt_q        <= '0;
            victim_vld_q <= 1'b0;
            victim_q     <= '0;
            victim_oh_q  <= '0;
            victim_ok_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            victim_vld_q <= victim_vld_d;
            victim_q     <= victim_d;
            victim_oh_q  <= victim_oh_d;
            victim_ok_q  <= victim_ok_d;
        end
    end

    // Tree storage: needs no reset because the clear sequence follows reset.
    always_ff @(posedge clk) begin
        if (resetn) begin
            if (busy)         tree_q[cnt_q]     <= '0;
            else if (upd_acc) tree_q[upd_index] <= upd_new;
        end
    end

    assign victim_vld = victim_vld_q;
    assign victim     = victim_q;
    assign victim_oh  = victim_oh_q;
    assign victim_ok  = victim_ok_q;

endmodule

`default_nettype wire

// File: tb/tb_tree_plru_array.sv
// ============================================================================
// Module      : tb_tree_plru_array
// Description : Directed self-checking bench for tree_plru_array (WAYS=4,
//               SETS=128) with hand-computed expected victims.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tree_plru_array;

    localparam int WAYS = 4;
    localparam int SETS = 128;

    logic       clk = 1'b0;
    logic       resetn;
    logic       flush;
    logic       busy;
    logic       rd_en;
    logic [6:0] rd_index;
    logic [3:0] rd_valid;
    logic [3:0] lock_mask;
    logic       victim_vld;
    logic [1:0] victim;
    logic [3:0] victim_oh;
    logic       victim_ok;
    logic       upd_en;
    logic [6:0] upd_index;
    logic [3:0] upd_way_oh;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tree_plru_array #(.WAYS(WAYS), .SETS(SETS)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .flush      (flush),
        .busy       (busy),
        .rd_en      (rd_en),
        .rd_index   (rd_index),
        .rd_valid   (rd_valid),
        .lock_mask  (lock_mask),
        .victim_vld (victim_vld),
        .victim     (victim),
        .victim_oh  (victim_oh),
        .victim_ok  (victim_ok),
        .upd_en     (upd_en),
        .upd_index  (upd_index),
        .upd_way_oh (upd_way_oh)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [6:0] idx, input logic [3:0] vld, input logic [3:0] lk);
        rd_en     = 1'b1;
        rd_index  = idx;
        rd_valid  = vld;
        lock_mask = lk;
        step();
        rd_en     = 1'b0;
    endtask

    task automatic update(input logic [6:0] idx, input logic [3:0] oh);
        upd_en     = 1'b1;
        upd_index  = idx;
        upd_way_oh = oh;
        step();
        upd_en     = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 1000) begin
            n++;
            step();
        end
    endtask

    initial begin
        int n;
        logic seen;

        resetn = 1'b0; flush = 1'b0;
        rd_en = 1'b1; rd_index = '0; rd_valid = 4'hF; lock_mask = '0;
        upd_en = 1'b0; upd_index = '0; upd_way_oh = '0;
        repeat (3) step();
        check("rst_vld", victim_vld, 0);
        check("rst_ok", victim_ok, 0);
        check("rst_oh", victim_oh, 0);
        check("rst_busy", busy, 1);
        rd_en  = 1'b0;
        resetn = 1'b1;
        wait_idle(n);
        check("rst_busy_len", n, SETS);

        // Freshly cleared set: all valid, nothing locked -> way 0
        lookup(7'd5, 4'hF, 4'h0);
        check("s5_vld", victim_vld, 1);
        check("s5_victim", victim, 0);
        check("s5_oh", victim_oh, 4'b0001);
        check("s5_ok", victim_ok, 1);
        step();
        check("no_rd_vld", victim_vld, 0);

        // Touch way 0 -> points right, then left -> way 2
        update(7'd5, 4'b0001);
        lookup(7'd5, 4'hF, 4'h0);
        check("s5_after_w0", victim, 2);
        // Touch way 2 -> root left, node1 still right -> way 1
        update(7'd5, 4'b0100);
        lookup(7'd5, 4'hF, 4'h0);
        check("s5_after_w2", victim, 1);

        // Invalid way wins over tree
        lookup(7'd3, 4'b1011, 4'h0);
        check("s3_inv_fresh", victim, 2);
        update(7'd3, 4'b0001);
        lookup(7'd3, 4'b1011, 4'h0);
        check("s3_inv_touched", victim, 2);
        // Invalid way 2 locked: walk right, left leaf locked -> way 3
        lookup(7'd3, 4'b1011, 4'b0100);
        check("s3_locked_walk", victim, 3);

        // Left subtree fully locked on a fresh set
        lookup(7'd7, 4'hF, 4'b0011);
        check("s7_lock_left", victim, 2);
        lookup(7'd7, 4'hF, 4'hF);
        check("s7_all_ok", victim_ok, 0);
        check("s7_all_oh", victim_oh, 0);
        check("s7_all_victim", victim, 0);
        check("s7_all_vld", victim_vld, 1);

        // Same-cycle update and lookup on one set: forwarded result
        upd_en = 1'b1; upd_index = 7'd9; upd_way_oh = 4'b0001;
        lookup(7'd9, 4'hF, 4'h0);
        upd_en = 1'b0;
        check("fwd_s9", victim, 2);
        // Update elsewhere must not disturb the looked-up set
        upd_en = 1'b1; upd_index = 7'd9; upd_way_oh = 4'b0001;
        lookup(7'd10, 4'hF, 4'h0);
        upd_en = 1'b0;
        check("nofwd_s10", victim, 0);
        lookup(7'd9, 4'hF, 4'h0);
        check("s9_persist", victim, 2);

        // Highest set bit wins: way 3 touched -> way 0 (way 0 would give 2)
        update(7'd11, 4'b1001);
        lookup(7'd11, 4'hF, 4'h0);
        check("hi_bit_wins", victim, 0);
        // All-zero one-hot is no update
        update(7'd12, 4'b0001);
        update(7'd12, 4'b0000);
        lookup(7'd12, 4'hF, 4'h0);
        check("zero_oh_noupd", victim, 2);

        // Flush, restarted 3 cycles in; lookups and updates ignored meanwhile
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_busy_next", busy, 1);
        rd_en = 1'b1; rd_index = 7'd5; rd_valid = 4'hF; lock_mask = 4'h0;
        upd_en = 1'b1; upd_index = 7'd0; upd_way_oh = 4'b0001;
        n = 0;
        seen = 1'b0;
        while (busy && n < 1000) begin
            n++;
            flush = (n == 3);
            step();
            if (victim_vld) seen = 1'b1;
        end
        flush = 1'b0; rd_en = 1'b0; upd_en = 1'b0;
        check("flush_len", n, SETS + 3);
        check("flush_rd_ignored", seen, 0);

        lookup(7'd0, 4'hF, 4'h0);
        check("clr_s0", victim, 0);
        lookup(7'd3, 4'hF, 4'h0);
        check("clr_s3", victim, 0);
        lookup(7'd5, 4'hF, 4'h0);
        check("clr_s5", victim, 0);
        lookup(7'd9, 4'hF, 4'h0);
        check("clr_s9", victim, 0);
        lookup(7'd12, 4'hF, 4'h0);
        check("clr_s12", victim, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
